stream_pair_packer: RTL and testbench
=====================================

STREAM_PAIR_PACKER -- requirements
Module: stream_pair_packer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10, giving the signed sample width.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, giving the pair-counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 enable  input  1  clock-enable; when 0, all state and outputs hold.
REQ-006 inReady  input  1  sample valid on in this cycle.
REQ-007 inLast  input  1  qualifies the in sample as the final element of a vector; meaningful only with inReady.
REQ-008 in  input  IN_WIDTH  signed sample.
REQ-009 outReady  output  1  registered; O0/O1 hold a valid pair this cycle.
REQ-010 O0, O1  output  IN_WIDTH each  registered signed pair; O0 is the earlier sample.
REQ-011 outLast  output  1  registered; the pair on O0/O1 closes the vector.
REQ-012 pairCount  output  CNT_WIDTH  registered count of pairs emitted in the current vector, including the current one.
REQ-013 earlyOutReady  output  1  combinational; high exactly when outReady will be 1 after the next enabled edge.

Function
REQ-014 SHALL implement two states: EMPTY (no sample held) and HALF (one sample held in an internal register).
REQ-015 EMPTY, enable=1, inReady=1, inLast=0: store in; go to HALF; outReady <= 0.
REQ-016 EMPTY, enable=1, inReady=1, inLast=1: O0 <= in, O1 <= 0 (zero pad), outReady <= 1, outLast <= 1; stay in EMPTY.
REQ-017 HALF, enable=1, inReady=1: O0 <= held, O1 <= in, outReady <= 1, outLast <= inLast; go to EMPTY.
REQ-018 Any state, enable=1, inReady=0: outReady <= 0, outLast <= 0; state, held sample, O0 and O1 unchanged.
REQ-019 enable=0: every register, including outReady, holds its value regardless of inReady.
REQ-020 Latency from the second sample of a pair (or a lone last sample) to outReady SHALL be exactly 1 enabled cycle.
REQ-021 SHALL accept one sample per enabled cycle indefinitely, with no backpressure.
REQ-022 pairCount SHALL increment on each emitted pair; the pair following an outLast pair SHALL show pairCount=1.
REQ-023 pairCount SHALL wrap modulo 2^CNT_WIDTH without error indication.
REQ-024 O0/O1 are unchanged when outReady is 0; downstream SHALL sample them only with outReady.
REQ-025 earlyOutReady = inReady AND (state==HALF OR inLast); it SHALL ignore enable.
REQ-026 No arithmetic on samples; pairs pass bit-exact, with zero pad only per REQ-016.

Reset
REQ-027 Reset low SHALL force asynchronously: state EMPTY, held sample 0, O0=0, O1=0, outReady=0, outLast=0, pairCount=0.
REQ-028 A half-collected pair at reset SHALL be discarded; no partial output after release.
REQ-029 First sample after reset release SHALL be treated as the start of a new vector.

Structure
REQ-030 State encoding constants (EMPTY, HALF) SHALL live in the shared linear-algebra package for reuse by tree-level controllers.
REQ-031 SHALL be a single flat module; no sub-module instances.
REQ-032 O0/O1/outReady SHALL connect directly to I0/I1/inReady of the registered 2-to-1 adder with matching IN_WIDTH.

Verification (IN_WIDTH=10)
REQ-033 After reset, samples 5, -3, 7, 2 (inLast on 2), one per cycle -> pairs (5,-3) then (7,2), outLast on the second pair, pairCount 1, 2.
REQ-034 Odd vector 4, 9, -1 (inLast on -1) -> pairs (4,9) then (-1,0), outLast=1, pairCount=2; next vector starts at pairCount=1.
REQ-035 Sample 6 sent, enable=0 for 3 cycles with inReady=1 on in=8, then enable=1 with 8 -> single pair (6,8); nothing emitted during the stall; outReady held.
REQ-036 Sample 11 held (HALF), reset pulsed low mid-cycle -> outputs zero immediately; next samples 1, 2 -> pair (1,2), not (11,x).
REQ-037 Extremes 511 and -512 -> O0=511, O1=-512 bit-exact; earlyOutReady high exactly one cycle before each outReady.
REQ-038 CNT_WIDTH=2, vector of 10 samples -> pairCount sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/stream_pair_packer_pkg.sv
// Shared state encodings for the pair packer and for tree-level controllers
// that need to track whether a packer is holding an unpaired sample.
package stream_pair_packer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_e;

    localparam int unsigned PACK_IN_WIDTH_DEFAULT  = 10;
    localparam int unsigned PACK_CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/stream_pair_packer_if.sv
// Sample stream in, registered pair stream out; the master drives samples and
// enable, the slave (the packer) drives the pair outputs.
interface stream_pair_packer_if #(
    parameter int unsigned IN_WIDTH  = 10,
    parameter int unsigned CNT_WIDTH = 8
);
    logic                        enable;
    logic                        inReady;
    logic                        inLast;
    logic signed [IN_WIDTH-1:0]  in;
    logic                        outReady;
    logic signed [IN_WIDTH-1:0]  O0;
    logic signed [IN_WIDTH-1:0]  O1;
    logic                        outLast;
    logic        [CNT_WIDTH-1:0] pairCount;
    logic                        earlyOutReady;

    modport master (
        output enable, inReady, inLast, in,
        input  outReady, O0, O1, outLast, pairCount, earlyOutReady
    );

    modport slave (
        input  enable, inReady, inLast, in,
        output outReady, O0, O1, outLast, pairCount, earlyOutReady
    );
endinterface

// File: rtl/stream_pair_packer.sv
// Packs consecutive signed samples into registered pairs, zero-padding a lone last sample.
// Latency 1 enabled cycle from the completing sample; never backpressures, one sample per cycle.
module stream_pair_packer
    import stream_pair_packer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = PACK_IN_WIDTH_DEFAULT,
    parameter int unsigned CNT_WIDTH = PACK_CNT_WIDTH_DEFAULT
) (
    input logic                 clk,
    input logic                 reset,
    stream_pair_packer_if.slave pk
);

    pack_state_e                 state_q, state_d;
    logic signed [IN_WIDTH-1:0]  held_q, held_d;
    logic signed [IN_WIDTH-1:0]  o0_q, o0_d;
    logic signed [IN_WIDTH-1:0]  o1_q, o1_d;
    logic                        out_ready_q, out_ready_d;
    logic                        out_last_q, out_last_d;
    logic        [CNT_WIDTH-1:0] pair_count_q, pair_count_d;
    // Set once a closing pair is emitted so the next pair restarts the count at 1.
    logic                        vec_done_q, vec_done_d;
    logic                        emit;
    logic                        emit_last;

    assign emit      = pk.inReady && (state_q == HALF || pk.inLast);
    assign emit_last = (state_q == HALF) ? pk.inLast : 1'b1;

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        o0_d         = o0_q;
        o1_d         = o1_q;
        out_ready_d  = out_ready_q;
        out_last_d   = out_last_q;
        pair_count_d = pair_count_q;
        vec_done_d   = vec_done_q;

        if (pk.enable) begin
            out_ready_d = 1'b0;
            out_last_d  = 1'b0;
            if (pk.inReady) begin
                if (emit) begin
                    o0_d         = (state_q == HALF) ? held_q : pk.in;
                    o1_d         = (state_q == HALF) ? pk.in : '0;
                    out_ready_d  = 1'b1;
                    out_last_d   = emit_last;
                    pair_count_d = vec_done_q ? CNT_WIDTH'(1) : pair_count_q + 1'b1;
                    vec_done_d   = emit_last;
                    state_d      = EMPTY;
                end else begin
                    held_d  = pk.in;
                    state_d = HALF;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= EMPTY;
            held_q       <= '0;
            o0_q         <= '0;
            o1_q         <= '0;
            out_ready_q  <= 1'b0;
            out_last_q   <= 1'b0;
            pair_count_q <= '0;
            vec_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            o0_q         <= o0_d;
            o1_q         <= o1_d;
            out_ready_q  <= out_ready_d;
            out_last_q   <= out_last_d;
            pair_count_q <= pair_count_d;
            vec_done_q   <= vec_done_d;
        end
    end

    assign pk.outReady      = out_ready_q;
    assign pk.O0            = o0_q;
    assign pk.O1            = o1_q;
    assign pk.outLast       = out_last_q;
    assign pk.pairCount     = pair_count_q;
    // Deliberately ignores enable: it predicts the result of the next enabled edge.
    assign pk.earlyOutReady = emit;

endmodule

// File: tb/tb_stream_pair_packer.sv
// Directed checks of the pair packer: pairing, zero pad, stalls, reset and counter wrap.
module tb_stream_pair_packer;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    stream_pair_packer_if #(.IN_WIDTH(10), .CNT_WIDTH(8)) p ();
    stream_pair_packer_if #(.IN_WIDTH(10), .CNT_WIDTH(2)) p2 ();

    assign p2.enable  = p.enable;
    assign p2.inReady = p.inReady;
    assign p2.inLast  = p.inLast;
    assign p2.in      = p.in;

    stream_pair_packer #(.IN_WIDTH(10), .CNT_WIDTH(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .pk    (p.slave)
    );

    stream_pair_packer #(.IN_WIDTH(10), .CNT_WIDTH(2)) u_dut_c2 (
        .clk   (clk),
        .reset (reset),
        .pk    (p2.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] s10(input int v);
        return v[9:0];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic en, input logic rdy, input logic last, input int val);
        p.enable  = en;
        p.inReady = rdy;
        p.inLast  = last;
        p.in      = s10(val);
    endtask

    // Inputs are applied just after a falling edge; outputs are sampled on the next falling edge.
    task automatic send(input string tag, input logic en, input logic rdy, input logic last,
                        input int val, input logic exp_early);
        set_in(en, rdy, last, val);
        #1;
        check_eq({tag, "_early"}, {31'd0, p.earlyOutReady}, {31'd0, exp_early});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_pair(input string tag, input int o0, input int o1, input logic last, input int pc);
        check_eq({tag, "_rdy"},  {31'd0, p.outReady}, 32'd1);
        check_eq({tag, "_o0"},   {22'd0, p.O0}, {22'd0, s10(o0)});
        check_eq({tag, "_o1"},   {22'd0, p.O1}, {22'd0, s10(o1)});
        check_eq({tag, "_last"}, {31'd0, p.outLast}, {31'd0, last});
        check_eq({tag, "_pc"},   {24'd0, p.pairCount}, 32'(pc));
    endtask

    task automatic chk_idle(input string tag, input int o0_held);
        check_eq({tag, "_rdy"}, {31'd0, p.outReady}, 32'd0);
        check_eq({tag, "_o0"},  {22'd0, p.O0}, {22'd0, s10(o0_held)});
    endtask

    int exp_c2 [5] = '{1, 2, 3, 0, 1};

    initial begin
        set_in(1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        check_eq("rst_rdy",  {31'd0, p.outReady}, 32'd0);
        check_eq("rst_o0",   {22'd0, p.O0}, 32'd0);
        check_eq("rst_o1",   {22'd0, p.O1}, 32'd0);
        check_eq("rst_last", {31'd0, p.outLast}, 32'd0);
        check_eq("rst_pc",   {24'd0, p.pairCount}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Even vector 5,-3,7,2
        send("v1a", 1, 1, 0, 5, 0);   chk_idle("v1a", 0);
        send("v1b", 1, 1, 0, -3, 1);  chk_pair("v1b", 5, -3, 0, 1);
        send("v1c", 1, 1, 0, 7, 0);   chk_idle("v1c", 5);
        send("v1d", 1, 1, 1, 2, 1);   chk_pair("v1d", 7, 2, 1, 2);

        // Odd vector 4,9,-1 with zero-padded closing pair
        send("v2a", 1, 1, 0, 4, 0);   chk_idle("v2a", 7);
        send("v2b", 1, 1, 0, 9, 1);   chk_pair("v2b", 4, 9, 0, 1);
        send("v2c", 1, 1, 1, -1, 1);  chk_pair("v2c", -1, 0, 1, 2);

        // Stall with a held sample: nothing emitted while enable is low
        send("st_a", 1, 1, 0, 6, 0);  chk_idle("st_a", -1);
        for (int i = 0; i < 3; i++) begin
            send("st_hold", 0, 1, 0, 8, 1);
            chk_idle("st_hold", -1);
        end
        send("st_b", 1, 1, 0, 8, 1);  chk_pair("st_b", 6, 8, 0, 1);
        send("st_frz", 0, 0, 0, 0, 0); chk_pair("st_frz", 6, 8, 0, 1);
        send("st_gap", 1, 0, 0, 0, 0); chk_idle("st_gap", 6);
        check_eq("st_gap_last", {31'd0, p.outLast}, 32'd0);
        check_eq("st_gap_pc",   {24'd0, p.pairCount}, 32'd1);

        // Asynchronous reset while half a pair is held
        send("rh_a", 1, 1, 0, 11, 0);
        #2 reset = 1'b0;
        #1;
        check_eq("rh_o0",  {22'd0, p.O0}, 32'd0);
        check_eq("rh_o1",  {22'd0, p.O1}, 32'd0);
        check_eq("rh_rdy", {31'd0, p.outReady}, 32'd0);
        check_eq("rh_pc",  {24'd0, p.pairCount}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        send("rh_b", 1, 1, 0, 1, 0);  chk_idle("rh_b", 0);
        send("rh_c", 1, 1, 0, 2, 1);  chk_pair("rh_c", 1, 2, 0, 1);

        // Extremes and a lone last sample
        send("ex_a", 1, 1, 0, 511, 0);  chk_idle("ex_a", 1);
        send("ex_b", 1, 1, 1, -512, 1); chk_pair("ex_b", 511, -512, 1, 2);
        send("ex_c", 1, 0, 1, 0, 0);    chk_idle("ex_c", 511);
        send("lone", 1, 1, 1, -7, 1);   chk_pair("lone", -7, 0, 1, 1);

        // Ten-sample vector: 2-bit counter wraps, 8-bit counter does not
        for (int i = 1; i <= 10; i++) begin
            set_in(1'b1, 1'b1, (i == 10), i);
            @(posedge clk);
            @(negedge clk);
            if (i % 2 == 0) begin
                check_eq("wrap_pc2", {30'd0, p2.pairCount}, 32'(exp_c2[i/2-1]));
                check_eq("wrap_pc8", {24'd0, p.pairCount}, 32'(i / 2));
                check_eq("wrap_o1",  {22'd0, p2.O1}, {22'd0, s10(i)});
            end
        end
        check_eq("wrap_last", {31'd0, p2.outLast}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
